// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule engine: loads a cipher key and streams the
// expanded words w[0..NW-1] over a valid/ready handshake, one per cycle.

module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine map.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            word_valid,
  input  logic            word_ready,
  output logic [31:0]     word_out,
  output logic [5:0]      word_idx,
  output logic            done
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NK);

  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     win_reg [NK];
  logic [31:0]     key_words [NK];
  logic [31:0]     word_reg;
  logic [5:0]      idx_reg;
  logic [IW-1:0]   mod_reg;
  logic [7:0]      rcon_reg;
  logic [31:0]     temp_word, sub_in, sub_out, calc_word, next_word;
  logic            key_phase, xfer, last_word;

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_key_expander: NK must be 4, 6 or 8");
    end
  endgenerate

  genvar gi;
  for (gi = 0; gi < NK; gi++) begin : g_key
    assign key_words[gi] = key_in[32*(NK-gi)-1 -: 32];
  end

  for (gi = 0; gi < 4; gi++) begin : g_sbox
    sbox u_sbox (.in_byte(sub_in[8*gi +: 8]), .out_byte(sub_out[8*gi +: 8]));
  end

  // mod_reg tracks (index of the next word) mod NK; window taps are fixed.
  assign xfer      = (state_reg == EMIT) && word_ready;
  assign last_word = (idx_reg == 6'(NW - 1));
  assign key_phase = (idx_reg < 6'(NK - 1));
  assign temp_word = win_reg[NK-1];
  assign sub_in    = (mod_reg == '0) ? {temp_word[23:0], temp_word[31:24]} : temp_word;

  always_comb begin
    if (mod_reg == '0)
      calc_word = win_reg[0] ^ sub_out ^ {rcon_reg, 24'h0};
    else if (NK == 8 && mod_reg == IW'(4))
      calc_word = win_reg[0] ^ sub_out;
    else
      calc_word = win_reg[0] ^ temp_word;
    next_word = key_phase ? win_reg[mod_reg] : calc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (xfer && last_word) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key words stay put in the window until the first derived word; after
  // that every accepted word shifts in and the oldest drops out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) win_reg[k] <= '0;
      word_reg <= '0;
      idx_reg  <= '0;
      mod_reg  <= '0;
      rcon_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      for (int k = 0; k < NK; k++) win_reg[k] <= key_words[k];
      word_reg <= key_words[0];
      idx_reg  <= '0;
      mod_reg  <= IW'(1);
      rcon_reg <= 8'h01;
    end else if (xfer && !last_word) begin
      word_reg <= next_word;
      idx_reg  <= idx_reg + 6'd1;
      mod_reg  <= (mod_reg == IW'(NK - 1)) ? '0 : mod_reg + IW'(1);
      if (!key_phase) begin
        for (int k = 0; k < NK - 1; k++) win_reg[k] <= win_reg[k+1];
        win_reg[NK-1] <= calc_word;
        if (mod_reg == '0)
          rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
      end
    end
  end

  assign busy       = (state_reg != IDLE);
  assign word_valid = (state_reg == EMIT);
  assign done       = (state_reg == FINISH);
  assign word_out   = word_reg;
  assign word_idx   = idx_reg;
endmodule
